// File: rtl/font_glyph_reader.sv
// font_glyph_reader
//
// Read-side client of the font RAM. Accepts character requests from the
// text-mode pipeline and turns each into one font RAM read. It captures the
// selected glyph byte in a hold buffer, then serialises it MSB-first into a
// pixel stream paced by pix_en. The hold buffer and the shifter form a double
// buffer, so the next glyph is fetched while the current one shifts out.
//
// Optional feature macro: FONT_ATTR_EN
//   defined   : per-glyph {fg,bg} attribute colours the pixels.
//   undefined : req_attr is ignored and pixels are 4'hF / 4'h0.
//
// Ports:
//   clk          system clock, shared with the font RAM
//   rst_n        asynchronous active-low reset
//   req_valid    character request valid
//   req_ready    request accepted when req_valid && req_ready
//   req_char     character code
//   req_row      glyph scanline 0..7
//   req_attr     {fg[7:4], bg[3:0]}, used only with FONT_ATTR_EN
//   font_addr    font RAM read address (registered)
//   font_data    font RAM read data, valid one cycle after font_addr
//   pix_en       pixel strobe, one pixel consumed per asserted cycle
//   pix_valid    pix_color holds a real glyph pixel
//   pix_color    pixel colour index
//   underrun     sticky, set when pix_en finds no pixel available
//   underrun_clr clears underrun, wins over a simultaneous set

module font_glyph_reader #(
   parameter logic [15:0] FONT_BASE            = 16'h0000,
   parameter int          WORDS_PER_GLYPH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_char,
   input  logic [2:0]  req_row,
   input  logic [7:0]  req_attr,
   output logic [15:0] font_addr,
   input  logic [15:0] font_data,
   input  logic        pix_en,
   output logic        pix_valid,
   output logic [3:0]  pix_color,
   output logic        underrun,
   input  logic        underrun_clr
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_CAPT = 2'd2;

   logic [1:0]  state_q,     state_d;
   logic [15:0] font_addr_q, font_addr_d;
   logic        byte_sel_q,  byte_sel_d;
   logic [7:0]  hold_byte_q, hold_byte_d;
   logic        hold_full_q, hold_full_d;
   logic [7:0]  shift_q,     shift_d;
   logic [2:0]  cnt_q,       cnt_d;
   logic        sh_valid_q,  sh_valid_d;
   logic        pix_valid_q, pix_valid_d;
   logic [3:0]  pix_color_q, pix_color_d;
   logic        underrun_q,  underrun_d;

`ifdef FONT_ATTR_EN
   logic [7:0]  req_attr_q,  req_attr_d;
   logic [7:0]  hold_attr_q, hold_attr_d;
   logic [7:0]  sh_attr_q,   sh_attr_d;
   logic [7:0]  cur_attr;
`else
   logic        unused_attr;
   assign unused_attr = ^req_attr;
`endif

   logic        accept;
   logic        capt;
   logic [7:0]  capt_byte;
   logic [15:0] glyph_addr;
   logic        sh_last;
   logic        xfer;
   logic        have_pix;
   logic        cur_bit;
   logic [3:0]  cur_color;

   // Word address of the requested scanline; two scanlines share a 16-bit word.
   // The sum wraps at 16 bits on purpose.
   assign glyph_addr = FONT_BASE
                     + (16'(req_char) << WORDS_PER_GLYPH_LOG2)
                     + 16'(req_row[2:1]);

   // Ready is gated by rst_n so it reads 0 throughout reset and 1 on the
   // very first cycle after release.
   assign req_ready = rst_n && (state_q == ST_IDLE) && !hold_full_q;
   assign accept    = req_valid && req_ready;
   assign capt      = (state_q == ST_CAPT);
   assign capt_byte = byte_sel_q ? font_data[15:8] : font_data[7:0];

   assign font_addr = font_addr_q;
   assign pix_valid = pix_valid_q;
   assign pix_color = pix_color_q;
   assign underrun  = underrun_q;

   // Request FSM: IDLE accepts and launches the read, WAIT covers the RAM's
   // registered read, CAPT is the cycle in which font_data is valid.
   always_comb begin
      state_d     = state_q;
      font_addr_d = font_addr_q;
      byte_sel_d  = byte_sel_q;
`ifdef FONT_ATTR_EN
      req_attr_d  = req_attr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               font_addr_d = glyph_addr;
               byte_sel_d  = req_row[0];
`ifdef FONT_ATTR_EN
               req_attr_d  = req_attr;
`endif
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: state_d = ST_CAPT;
         ST_CAPT: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Hold buffer, shifter and pixel output. The counter stores the number of
   // pixels left minus one, so cnt_q == 0 with sh_valid_q marks the last pixel.
   // When the shifter is empty but the hold buffer is full, the hold MSB is
   // emitted directly and the remaining seven bits are loaded, so a waiting
   // glyph never costs a bubble.
   always_comb begin
      sh_last     = sh_valid_q && (cnt_q == 3'd0);
      xfer        = pix_en && hold_full_q && (!sh_valid_q || sh_last);

      have_pix    = 1'b0;
      cur_bit     = 1'b0;
`ifdef FONT_ATTR_EN
      cur_attr    = 8'h00;
`endif
      if (sh_valid_q) begin
         have_pix = 1'b1;
         cur_bit  = shift_q[7];
`ifdef FONT_ATTR_EN
         cur_attr = sh_attr_q;
`endif
      end else if (hold_full_q) begin
         have_pix = 1'b1;
         cur_bit  = hold_byte_q[7];
`ifdef FONT_ATTR_EN
         cur_attr = hold_attr_q;
`endif
      end

`ifdef FONT_ATTR_EN
      cur_color = cur_bit ? cur_attr[7:4] : cur_attr[3:0];
`else
      cur_color = {4{cur_bit}};
`endif

      shift_d     = shift_q;
      cnt_d       = cnt_q;
      sh_valid_d  = sh_valid_q;
`ifdef FONT_ATTR_EN
      sh_attr_d   = sh_attr_q;
`endif
      pix_valid_d = pix_valid_q;
      pix_color_d = pix_color_q;

      if (pix_en) begin
         pix_valid_d = have_pix;
         pix_color_d = have_pix ? cur_color : 4'h0;
         if (sh_valid_q && !sh_last) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q - 3'd1;
         end else if (xfer) begin
            sh_valid_d = 1'b1;
`ifdef FONT_ATTR_EN
            sh_attr_d  = hold_attr_q;
`endif
            if (sh_valid_q) begin
               shift_d = hold_byte_q;
               cnt_d   = 3'd7;
            end else begin
               shift_d = {hold_byte_q[6:0], 1'b0};
               cnt_d   = 3'd6;
            end
         end else begin
            sh_valid_d = 1'b0;
            shift_d    = 8'h00;
            cnt_d      = 3'd0;
         end
      end

      // A capture and a transfer in the same cycle leave the buffer full.
      hold_full_d = capt || (hold_full_q && !xfer);
      hold_byte_d = capt ? capt_byte : hold_byte_q;
`ifdef FONT_ATTR_EN
      hold_attr_d = capt ? req_attr_q : hold_attr_q;
`endif

      underrun_d  = underrun_clr ? 1'b0 : (underrun_q || (pix_en && !have_pix));
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         font_addr_q <= FONT_BASE;
         byte_sel_q  <= 1'b0;
         hold_byte_q <= 8'h00;
         hold_full_q <= 1'b0;
         shift_q     <= 8'h00;
         cnt_q       <= 3'd0;
         sh_valid_q  <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_color_q <= 4'h0;
         underrun_q  <= 1'b0;
`ifdef FONT_ATTR_EN
         req_attr_q  <= 8'h00;
         hold_attr_q <= 8'h00;
         sh_attr_q   <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         font_addr_q <= font_addr_d;
         byte_sel_q  <= byte_sel_d;
         hold_byte_q <= hold_byte_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         sh_valid_q  <= sh_valid_d;
         pix_valid_q <= pix_valid_d;
         pix_color_q <= pix_color_d;
         underrun_q  <= underrun_d;
`ifdef FONT_ATTR_EN
         req_attr_q  <= req_attr_d;
         hold_attr_q <= hold_attr_d;
         sh_attr_q   <= sh_attr_d;
`endif
      end
   end

endmodule

// File: tb/tb_font_glyph_reader.sv
// tb_font_glyph_reader
//
// Testbench for font_glyph_reader. A behavioural font RAM answers reads one
// cycle late. Every accepted request pushes its eight expected pixels into a
// queue, each tagged with the first clock edge at which it may be consumed.
// A monitor pops one pixel per pix_en edge and compares it, so the stimulus
// and the checking run independently. Runs with FONT_ATTR_EN on or off.

module tb_font_glyph_reader;

   localparam logic [15:0] FB  = 16'hFFFC;
   localparam int          WL2 = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_char;
   logic [2:0]  req_row;
   logic [7:0]  req_attr;
   logic [15:0] font_addr;
   logic [15:0] font_data;
   logic        pix_en;
   logic        pix_valid;
   logic [3:0]  pix_color;
   logic        underrun;
   logic        underrun_clr;

   font_glyph_reader #(
      .FONT_BASE           (FB),
      .WORDS_PER_GLYPH_LOG2(WL2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_char    (req_char),
      .req_row     (req_row),
      .req_attr    (req_attr),
      .font_addr   (font_addr),
      .font_data   (font_data),
      .pix_en      (pix_en),
      .pix_valid   (pix_valid),
      .pix_color   (pix_color),
      .underrun    (underrun),
      .underrun_clr(underrun_clr)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Font RAM with a registered read port.
   logic [15:0] mem [0:65535];
   always @(posedge clk) font_data <= mem[font_addr];

   typedef struct {
      logic [3:0] color;
      int         avail;
   } pix_t;

   pix_t        pq[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          edge_cnt    = 0;
   logic        exp_valid   = 1'b0;
   logic [3:0]  exp_color   = 4'h0;
   logic        exp_under   = 1'b0;
   logic [15:0] exp_addr;
   logic        drv_hs;

   logic        s_rst, s_pix, s_clr, s_hs, under_set;
   logic [7:0]  s_char;
   logic [2:0]  s_row;
`ifdef FONT_ATTR_EN
   logic [7:0]  s_attr;
`endif

   // Font word address straight from the addressing rule, in integer arithmetic.
   function automatic logic [15:0] model_addr(input logic [7:0] c, input logic [2:0] r);
      int a;
      a = int'(FB) + int'(c) * (2 ** WL2) + int'(r) / 2;
      return a[15:0];
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Queue the eight pixels of an accepted glyph; usable from edge n+3 on.
   task automatic pushGlyph();
      logic [15:0] w;
      logic [7:0]  gbyte;
      logic        b;
      logic [3:0]  col;
      exp_addr = model_addr(s_char, s_row);
      w        = mem[exp_addr];
      gbyte    = s_row[0] ? w[15:8] : w[7:0];
      for (int i = 0; i < 8; i++) begin
         b = gbyte[7 - i];
`ifdef FONT_ATTR_EN
         col = b ? s_attr[7:4] : s_attr[3:0];
`else
         col = {4{b}};
`endif
         pq.push_back('{color: col, avail: edge_cnt + 3});
      end
   endtask

   // Monitor: sample inputs before the edge, advance the model on the edge,
   // compare registered outputs just after it.
   always begin
      @(negedge clk);
      s_rst  = rst_n;
      s_pix  = pix_en;
      s_clr  = underrun_clr;
      s_hs   = req_valid && req_ready;
      s_char = req_char;
      s_row  = req_row;
`ifdef FONT_ATTR_EN
      s_attr = req_attr;
`endif
      @(posedge clk);
      edge_cnt++;
      if (s_rst) begin
         under_set = 1'b0;
         if (s_hs) pushGlyph();
         if (s_pix) begin
            if (pq.size() > 0 && pq[0].avail <= edge_cnt) begin
               exp_valid = 1'b1;
               exp_color = pq[0].color;
               void'(pq.pop_front());
            end else begin
               exp_valid = 1'b0;
               exp_color = 4'h0;
               under_set = 1'b1;
            end
         end
         exp_under = s_clr ? 1'b0 : (exp_under | under_set);
         #1;
         if (rst_n) begin
            checkOutput("pix_valid", 16'(pix_valid), 16'(exp_valid));
            checkOutput("pix_color", 16'(pix_color), 16'(exp_color));
            checkOutput("underrun",  16'(underrun),  16'(exp_under));
            if (s_hs) checkOutput("font_addr", font_addr, exp_addr);
         end
      end
   end

   // One clock of stimulus; a request that was accepted on this edge is dropped.
   task automatic tick();
      @(negedge clk);
      drv_hs = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (drv_hs) req_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] c, input logic [2:0] r, input logic [7:0] a);
      int n;
      req_char  = c;
      req_row   = r;
      req_attr  = a;
      req_valid = 1'b1;
      n = 0;
      while (req_valid && n < 50) begin
         tick();
         n++;
      end
      if (req_valid) begin
         checkOutput("req_accept_timeout", 16'(req_valid), 16'h0);
         req_valid = 1'b0;
      end
   endtask

   task automatic applyReset();
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      pix_en       = 1'b0;
      underrun_clr = 1'b0;
      pq.delete();
      exp_valid = 1'b0;
      exp_color = 4'h0;
      exp_under = 1'b0;
      #1;
      checkOutput("rst_pix_valid", 16'(pix_valid), 16'h0);
      checkOutput("rst_pix_color", 16'(pix_color), 16'h0);
      checkOutput("rst_underrun",  16'(underrun),  16'h0);
      checkOutput("rst_req_ready", 16'(req_ready), 16'h0);
      checkOutput("rst_font_addr", font_addr, FB);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_req_ready", 16'(req_ready), 16'h1);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [15:0] a;
      int rate;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[model_addr(8'h41, 3'd3)] = 16'hA53C;
      a = model_addr(8'h10, 3'd0);
      mem[a][7:0] = 8'h80;

      rst_n = 1'b1; req_valid = 1'b0; req_char = 8'h00; req_row = 3'd0;
      req_attr = 8'h00; pix_en = 1'b0; underrun_clr = 1'b0;
      #2;
      applyReset();

      // Underrun with nothing queued, then clear racing a new underrun.
      tick();
      pix_en = 1'b1; tick();
      pix_en = 1'b0; tick();
      checkOutput("underrun_set", 16'(underrun), 16'h1);
      pix_en = 1'b1; underrun_clr = 1'b1; tick();
      pix_en = 1'b0; underrun_clr = 1'b0; tick();
      checkOutput("underrun_clr_wins", 16'(underrun), 16'h0);

      // Address and high-byte select: FFFC + 0x104 + 1 wraps to 0x0101.
      applyStimulus(8'h41, 3'd3, 8'h5A);
      checkOutput("addr_41_row3", font_addr, 16'h0101);
      repeat (3) tick();
      pix_en = 1'b1; repeat (8) tick(); pix_en = 1'b0;

      // Address wrap: FFFC + 4 wraps to 0.
      applyStimulus(8'h01, 3'd0, 8'hC3);
      checkOutput("addr_wrap", font_addr, 16'h0000);
      repeat (3) tick();
      pix_en = 1'b1; repeat (8) tick(); pix_en = 1'b0;

      // Attribute colouring of glyph byte 0x80.
      applyStimulus(8'h10, 3'd0, 8'h1E);
      repeat (3) tick();
      pix_en = 1'b1; repeat (8) tick(); pix_en = 1'b0;

      // Back-to-back glyphs with a continuous strobe.
      applyStimulus(8'h22, 3'd5, 8'h7B);
      req_char = 8'h9C; req_row = 3'd2; req_attr = 8'h4D; req_valid = 1'b1;
      tick();
      tick();
      checkOutput("ready_low_hold_full", 16'(req_ready), 16'h0);
      pix_en = 1'b1; repeat (16) tick(); pix_en = 1'b0;
      checkOutput("b2b_no_underrun", 16'(underrun), 16'h0);
      checkOutput("b2b_queue_drained", 16'(pq.size()), 16'h0);

      // Reset while a glyph is half shifted.
      applyStimulus(8'h5E, 3'd6, 8'h2F);
      repeat (3) tick();
      pix_en = 1'b1; repeat (4) tick();
      #2;
      applyReset();

      // Randomized traffic alternating dense and sparse request phases.
      for (int i = 0; i < 3000; i++) begin
         rate = ((i / 250) % 2 == 1) ? 60 : 8;
         if (!req_valid && $urandom_range(0, 99) < rate) begin
            req_char  = 8'($urandom);
            req_row   = 3'($urandom);
            req_attr  = 8'($urandom);
            req_valid = 1'b1;
         end
         pix_en       = ($urandom_range(0, 9) < 6);
         underrun_clr = ($urandom_range(0, 19) == 0);
         tick();
         if (i == 1500) begin
            #2;
            applyReset();
         end
      end
      req_valid = 1'b0; pix_en = 1'b0; underrun_clr = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
